// File: rtl/card_shoe_if.sv
// card_shoe_if: request/deal handshake between the blackjack game controller
// and the card shoe.
//   card_req      - request one card (sampled every cycle)
//   shuffle_req   - force a full reshuffle of all 52 cards
//   card_valid    - one-cycle pulse, card_rank/card_value valid
//   card_rank     - 1 = A, 2..10, 11 = J, 12 = Q, 13 = K
//   card_value    - blackjack value (A = 1, J/Q/K = 10)
//   cards_left    - undealt cards, 52..0
//   ready         - shoe can deal
//   empty         - deck exhausted and not shuffling
//   shuffle_done  - one-cycle pulse on entry to READY
// master: game controller side, slave: shoe side.
interface card_shoe_if;
  logic       card_req;
  logic       shuffle_req;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       ready;
  logic       empty;
  logic       shuffle_done;

  modport master (
    output card_req, shuffle_req,
    input  card_valid, card_rank, card_value, cards_left, ready, empty, shuffle_done
  );

  modport slave (
    input  card_req, shuffle_req,
    output card_valid, card_rank, card_value, cards_left, ready, empty, shuffle_done
  );
endinterface

// File: rtl/card_shoe.sv
// card_shoe: single 52-card deck. Shuffles in place with a Fisher-Yates pass
// driven by a seeded 16-bit Galois LFSR, then deals one card per request.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low
//   bus    - card_shoe_if.slave (requests in; card, counters and status out)
// Parameters:
//   LFSR_SEED      - shuffle seed; 0 is replaced by 16'h0001
//   AUTO_RESHUFFLE - 1: reshuffle right after the 52nd card, 0: park in EMPTY
module card_shoe #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter bit          AUTO_RESHUFFLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  card_shoe_if.slave  bus
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_SHUFFLE,
    S_READY,
    S_EMPTY
  } state_t;

  state_t      state;
  logic [3:0]  deck [52];
  logic [5:0]  idx;        // Fisher-Yates swap index, 51 down to 1
  logic [5:0]  ptr;        // next card to deal
  logic [15:0] lfsr;

  logic [5:0]  mask;
  logic [5:0]  j;
  logic        take;
  logic [3:0]  deck_i;
  logic [3:0]  deck_j;
  logic [3:0]  rank_now;
  logic [15:0] lfsr_next;

  always_comb begin
    // Smallest 2^n-1 covering idx keeps the rejection rate below 1/2.
    if (idx >= 6'd32)      mask = 6'd63;
    else if (idx >= 6'd16) mask = 6'd31;
    else if (idx >= 6'd8)  mask = 6'd15;
    else if (idx >= 6'd4)  mask = 6'd7;
    else if (idx >= 6'd2)  mask = 6'd3;
    else                   mask = 6'd1;
    j         = lfsr[5:0] & mask;
    take      = (j <= idx);
    deck_i    = deck[idx];
    deck_j    = deck[j];
    rank_now  = deck[ptr];
    lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ TAPS) : {1'b0, lfsr[15:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_SHUFFLE;
      idx              <= 6'd51;
      ptr              <= '0;
      lfsr             <= SEED;
      for (int unsigned k = 0; k < 52; k++)
        deck[k] <= 4'((k % 13) + 1);
      bus.card_valid   <= 1'b0;
      bus.card_rank    <= '0;
      bus.card_value   <= '0;
      bus.cards_left   <= 6'd52;
      bus.ready        <= 1'b0;
      bus.empty        <= 1'b0;
      bus.shuffle_done <= 1'b0;
    end else begin
      bus.card_valid   <= 1'b0;
      bus.shuffle_done <= 1'b0;
      case (state)
        S_SHUFFLE: begin
          lfsr <= lfsr_next;
          if (take) begin
            // Swap deck[idx] and deck[j]; j == idx degenerates to a rewrite.
            for (int unsigned k = 0; k < 52; k++) begin
              if (6'(k) == idx)    deck[k] <= deck_j;
              else if (6'(k) == j) deck[k] <= deck_i;
            end
            if (idx == 6'd1) begin
              ptr              <= '0;
              bus.cards_left   <= 6'd52;
              bus.ready        <= 1'b1;
              bus.shuffle_done <= 1'b1;
              state            <= S_READY;
            end else begin
              idx <= idx - 6'd1;
            end
          end
        end

        S_READY: begin
          if (bus.shuffle_req) begin
            // Shuffle wins over a simultaneous card request.
            idx       <= 6'd51;
            bus.ready <= 1'b0;
            state     <= S_SHUFFLE;
          end else if (bus.card_req && bus.cards_left != 6'd0) begin
            bus.card_valid <= 1'b1;
            bus.card_rank  <= rank_now;
            bus.card_value <= (rank_now > 4'd10) ? 4'd10 : rank_now;
            ptr            <= ptr + 6'd1;
            bus.cards_left <= bus.cards_left - 6'd1;
            if (bus.cards_left == 6'd1) begin
              bus.ready <= 1'b0;
              if (AUTO_RESHUFFLE) begin
                idx   <= 6'd51;
                state <= S_SHUFFLE;
              end else begin
                bus.empty <= 1'b1;
                state     <= S_EMPTY;
              end
            end
          end
        end

        S_EMPTY: begin
          if (bus.shuffle_req) begin
            idx       <= 6'd51;
            bus.empty <= 1'b0;
            state     <= S_SHUFFLE;
          end
        end

        default: state <= S_SHUFFLE;
      endcase
    end
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Single-deck card source for the blackjack game controller: holds 52 cards (ranks 1–13, four of each), shuffles them with a seeded LFSR, and deals one card per request over a request/valid handshake. Each card goes out with both its rank and its blackjack value, so the game FSM can consume it directly. The shoe replaces free-running card generation with a finite, non-repeating deck whose order is deterministic from the seed.

## Interface

**Parameters**
- LFSR_SEED, default 16'hACE1: shuffle LFSR seed. A seed of 0 is replaced by 16'h0001.
- AUTO_RESHUFFLE, default 1: when 1, the shoe reshuffles automatically after the 52nd card is dealt.

**Ports**
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- card_req, input, 1: request one card. Sampled each cycle.
- shuffle_req, input, 1: force a full reshuffle of all 52 cards.
- card_valid, output, 1: one-cycle pulse; card_rank and card_value are valid on this cycle.
- card_rank, output, 4: 1 = A, 2–10, 11 = J, 12 = Q, 13 = K.
- card_value, output, 4: blackjack value. Ace = 1, 2–10 at face value, J/Q/K = 10.
- cards_left, output, 6: number of undealt cards, 52..0.
- ready, output, 1: high while in READY (shoe can deal).
- empty, output, 1: high when cards_left == 0 and the shoe is not shuffling.
- shuffle_done, output, 1: one-cycle pulse on entry to READY.

## Operation

**Storage and LFSR**
- Deck storage is a 52×4-bit register array.
- On reset, entry k = (k mod 13) + 1 (sorted order).
- The LFSR is a 16-bit Galois LFSR with taps 16'hB400. It is loaded with the seed on reset and advances only in SHUFFLE (one step per cycle).

**States**
- SHUFFLE (the reset state)
  - Swap index i starts at 51.
  - Each cycle: j = lfsr[5:0] & mask(i), where mask is the smallest 2^n−1 ≥ i.
  - If j ≤ i: swap deck[i] and deck[j] (a no-op when j == i) and decrement i.
  - If j > i: reject. Nothing changes and the shuffle retries next cycle.
  - After the swap at i = 1 completes: deal pointer ← 0, cards_left ← 52, go to READY.
- READY
  - card_req with cards_left > 0 goes to a deal. On the next cycle:
    - card_valid = 1
    - card_rank = deck[ptr], card_value = min(rank, 10)
    - ptr increments and cards_left decrements.
  - Back-to-back requests deal one card per cycle.
  - shuffle_req restarts SHUFFLE at i = 51 and shuffles the current permutation.
- EMPTY
  - Entered after the 52nd card is dealt when AUTO_RESHUFFLE = 0.
  - empty = 1, and card_req is ignored (no card_valid).
  - shuffle_req leaves EMPTY for SHUFFLE.
- With AUTO_RESHUFFLE = 1, dealing the 52nd card goes straight to SHUFFLE instead of EMPTY.

**Boundary rules**
- card_req in SHUFFLE or EMPTY is dropped, not queued.
- shuffle_req and card_req in the same READY cycle: the shuffle wins and no card is dealt.
- shuffle_req during SHUFFLE is ignored; the shuffle in progress continues.
- card_rank and card_value hold the last dealt card after card_valid drops.
- Reset asserted mid-shuffle or mid-deal immediately restores the sorted deck, the seed, and all output reset values. The shuffle restarts from scratch after release.

## Timing

**Reset values**
- card_valid 0, card_rank 0, card_value 0, cards_left 52, ready 0, empty 0, shuffle_done 0.
- State is SHUFFLE with i = 51.

**Latency and handshake**
- Deal latency: card_req sampled high at edge N gives card_valid high in cycle N+1.
- cards_left updates on the same edge that raises card_valid.
- ready and shuffle_done rise together on the cycle READY is entered.
- ready drops on the cycle SHUFFLE or EMPTY is entered, including the cycle right after the 52nd card is dealt.

**Shuffle duration**
- At least 51 cycles; each rejection adds one cycle.
- Rejection probability per cycle is below 1/2, so expected duration is under 102 cycles.
- Duration is deterministic for a given seed.

**Counter limits**
- cards_left never underflows below 0 and never exceeds 52.

## Test plan

- **Initial shuffle:** release reset with the default seed. Required: shuffle_done pulses within 200 cycles. A dump of the deck by 52 back-to-back requests contains each rank 1–13 exactly 4 times, and the order is not sorted.
- **Back-to-back deal:** hold card_req for 52 cycles from READY. Required: card_valid on 52 consecutive cycles, cards_left steps 52→0, and card_value = 10 for every rank of 11–13.
- **Empty, AUTO_RESHUFFLE = 0:**
  - Deal 52 cards, then pulse card_req: no card_valid, empty = 1, cards_left = 0.
  - Then pulse shuffle_req: shuffle_done follows, and cards_left returns to 52.
- **Auto reshuffle, AUTO_RESHUFFLE = 1:** deal 52 cards. Required: ready = 0 on the next cycle and empty never asserts. Requests during SHUFFLE produce no card_valid, and shuffle_done fires afterward.
- **Simultaneous requests:** assert shuffle_req and card_req together after 10 cards are dealt. Required: no card_valid, ready falls, and after shuffle_done cards_left = 52.
- **Reset mid-shuffle:** assert reset at cycle 20 of the initial shuffle. Required: outputs return to their reset values. After release, the dealt sequence is identical to an uninterrupted run with the same seed, and a different LFSR_SEED yields a different sequence.
